// File: rtl/reg_bank_pkg.sv
// Shared operation encodings and parameter legality helper for reg_bank.
package reg_bank_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  // A bank depth is legal when it is a power of two of at least 2.
  function automatic bit legal_depth(input int unsigned depth);
    return (depth >= 32'd2) && ((depth & (depth - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/reg_bank_alu.sv
// In-place update unit: computes INC/DEC/SHL result and carry from one register.
module reg_bank_alu
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             in0,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] nxt,
  output logic             c_out
);

  // Result and carry/borrow/shift-out; LOAD passes cur through and is resolved by the parent.
  always_comb begin
    nxt   = cur;
    c_out = 1'b0;
    case (op)
      OP_INC:  {c_out, nxt} = {1'b0, cur} + (WIDTH+1)'(1);
      OP_DEC:  {c_out, nxt} = {1'b0, cur} - (WIDTH+1)'(1);
      OP_SHL: begin
        nxt   = {cur[WIDTH-2:0], in0};
        c_out = cur[WIDTH-1];
      end
      default: begin
        nxt   = cur;
        c_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Addressed register bank with in-place INC/DEC/SHL, carry flag, written mask and tri-state read port.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        op,
  input  logic              low_i_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              low_o_en,
  output logic [WIDTH-1:0]  out,
  output logic              carry,
  output logic              zero,
  output logic [DEPTH-1:0]  valid
);

  if (!legal_depth(DEPTH) || (WIDTH < 32'd2)) begin : g_param_check
    $error("reg_bank: DEPTH must be a power of two >= 2 and WIDTH >= 2");
  end

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] alu_nxt;
  logic             alu_c;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] rd_val;

  reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .cur   (regs[wr_addr]),
    .in0   (in[0]),
    .op    (op),
    .nxt   (alu_nxt),
    .c_out (alu_c)
  );

  // LOAD takes bus data directly; other ops take the ALU result.
  assign wr_val = (op == OP_LOAD) ? in : alu_nxt;

  // Single-register update per edge; reset overrides any requested operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
      carry <= 1'b0;
      valid <= '0;
    end else if (!low_i_en) begin
      regs[wr_addr]  <= wr_val;
      valid[wr_addr] <= 1'b1;
      if (op != OP_LOAD) begin
        carry <= alu_c;
      end
    end
  end

  // Read path straight from stored state, no bypass of the pending write.
  assign rd_val = regs[rd_addr];
  assign zero   = (rd_val == '0);
  assign out    = low_o_en ? 'z : rd_val;

endmodule
